// File: rtl/ifu_prefetch_pkg.sv
// ifu_prefetch_pkg: FSM encoding, latency bound, instruction stride and a saturating
// adder shared by the instruction-fetch unit.
package ifu_prefetch_pkg;

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_DS_WAIT = 1'b1
    } ifu_state_e;

    localparam int unsigned IFU_MAX_LAT = 4;
    localparam int unsigned INST_STRIDE = 4;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: show-ahead synchronous FIFO; keep_one collapses the queue to the entry
// following the (optionally popped) head.
module ifu_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     keep_one,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_next;

    assign rd_next = rd_ptr + PW'(pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !keep_one) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_next;
            // Surviving entry sits at rd_next; write pointer lands just behind it.
            if (keep_one) begin
                wr_ptr <= rd_next + PW'(1);
                count  <= FW'(1);
            end else begin
                wr_ptr <= wr_ptr + PW'(push);
                count  <= count + FW'(push) - FW'(pop);
            end
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: PC owner and ROM prefetcher with delay-slot preserving redirect.
// Define IFU_PERF_EN to add perf_fetch_o / perf_kill_o saturating counters.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ROM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    input  logic              id_ready_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_kill_o
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + IFU_MAX_LAT) + 1;
    localparam int unsigned FW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = ADDR_W + INST_W;

    ifu_state_e                     state;
    logic [ADDR_W-1:0]              fetch_pc;
    logic [ADDR_W-1:0]              saved_target;
    logic                           run_en;
    logic                           ds_pending;
    logic [ROM_LAT-1:0]             pipe_vld;
    logic [ROM_LAT-1:0][ADDR_W-1:0] pipe_pc;

    logic [FW-1:0]      fifo_count;
    logic [EW-1:0]      head;
    logic [CW-1:0]      occ;
    logic [CW-1:0]      in_flight;
    logic [ROM_LAT-1:0] oldest;
    logic [ROM_LAT-1:0] live;
    logic               valid;
    logic               pop;
    logic               push;
    logic               br;
    logic               keep_q;
    logic               keep_fl;
    logic               to_ds;
    logic               issue;

    always_comb begin
        occ       = CW'(fifo_count);
        in_flight = '0;
        oldest    = '0;
        for (int unsigned i = 0; i < ROM_LAT; i++) begin
            in_flight = in_flight + CW'(pipe_vld[i]);
            if (pipe_vld[i]) begin
                oldest    = '0;
                oldest[i] = 1'b1;
            end
        end
    end

    assign valid = (fifo_count != '0);
    assign pop   = valid & id_ready_i;
    // Branches are only taken in RUN and never from the delay-slot instruction itself.
    assign br      = pop & branch_flag_i & ~ds_pending & (state == S_RUN);
    assign keep_q  = br & (occ >= CW'(2));
    assign keep_fl = br & (occ == CW'(1)) & (in_flight != '0);
    assign to_ds   = br & (occ == CW'(1)) & (in_flight == '0);

    always_comb begin
        live = pipe_vld;
        if (keep_q) begin
            live = '0;
        end else if (keep_fl) begin
            live = pipe_vld & oldest;
        end
    end

    assign push  = live[ROM_LAT-1];
    assign issue = run_en & ~br & ((occ + in_flight) < CW'(DEPTH));

    assign rom_ce_o   = issue;
    assign rom_addr_o = fetch_pc;
    assign id_valid_o = valid;
    assign id_pc_o    = valid ? head[EW-1 -: ADDR_W] : '0;
    assign id_inst_o  = valid ? head[INST_W-1:0] : '0;

    ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({pipe_pc[ROM_LAT-1], rom_data_i}),
        .pop       (pop),
        .keep_one  (keep_q),
        .head      (head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_RUN;
            fetch_pc     <= RESET_PC;
            saved_target <= '0;
            run_en       <= 1'b0;
            ds_pending   <= 1'b0;
            pipe_vld     <= '0;
            pipe_pc      <= '0;
        end else begin
            run_en      <= 1'b1;
            pipe_vld[0] <= issue;
            pipe_pc[0]  <= fetch_pc;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                pipe_vld[i] <= live[i-1];
                pipe_pc[i]  <= pipe_pc[i-1];
            end

            if (br) begin
                ds_pending <= 1'b1;
            end else if (pop) begin
                ds_pending <= 1'b0;
            end

            case (state)
                S_RUN: begin
                    if (keep_q || keep_fl) begin
                        fetch_pc <= branch_target_i;
                    end else if (to_ds) begin
                        saved_target <= branch_target_i;
                        state        <= S_DS_WAIT;
                    end else if (issue) begin
                        fetch_pc <= fetch_pc + ADDR_W'(INST_STRIDE);
                    end
                end
                S_DS_WAIT: begin
                    // fetch_pc already holds branch_pc+4: fetch the delay slot, then jump.
                    if (issue) begin
                        fetch_pc <= saved_target;
                        state    <= S_RUN;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] kill_n;

    always_comb begin
        kill_n = '0;
        if (keep_q) begin
            kill_n = 32'(occ - CW'(2) + in_flight);
        end else if (keep_fl) begin
            kill_n = 32'(in_flight - CW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_o <= '0;
            perf_kill_o  <= '0;
        end else begin
            perf_fetch_o <= sat_add32(perf_fetch_o, 32'(issue));
            perf_kill_o  <= sat_add32(perf_kill_o, kill_n);
        end
    end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: two DUTs (ROM_LAT 1 and 3, DEPTH 4) against an architectural
// program-order model with delay-slot semantics; expected PCs are queued and popped per ID accept.
module tb_ifu_prefetch;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce        [NI];
    logic [31:0] rom_addr      [NI];
    logic [31:0] rom_data      [NI];
    logic        id_valid      [NI];
    logic [31:0] id_pc         [NI];
    logic [31:0] id_inst       [NI];
    logic        id_ready      [NI];
    logic        branch_flag   [NI];
    logic [31:0] branch_target [NI];
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch    [NI];
    logic [31:0] perf_kill     [NI];
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [31:0] ap [LAT];

        always_ff @(posedge clk) begin
            ap[0] <= rom_addr[g];
            for (int k = 1; k < int'(LAT); k++) ap[k] <= ap[k-1];
        end
        assign rom_data[g] = inst_of(ap[LAT-1]);

        ifu_prefetch #(
            .ADDR_W   (32),
            .INST_W   (32),
            .DEPTH    (4),
            .ROM_LAT  (LAT),
            .RESET_PC (32'h0)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .rom_ce_o        (rom_ce[g]),
            .rom_addr_o      (rom_addr[g]),
            .rom_data_i      (rom_data[g]),
            .id_valid_o      (id_valid[g]),
            .id_pc_o         (id_pc[g]),
            .id_inst_o       (id_inst[g]),
            .id_ready_i      (id_ready[g]),
            .branch_flag_i   (branch_flag[g]),
            .branch_target_i (branch_target[g])
`ifdef IFU_PERF_EN
            ,
            .perf_fetch_o    (perf_fetch[g]),
            .perf_kill_o     (perf_kill[g])
`endif
        );
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cur = 0;
    logic [31:0] sb [$];
    logic [31:0] stall_pc;
    int          stall_len;
    bit          rand_ready;
    int          nbr;
    logic [31:0] br_pc  [2];
    logic [31:0] br_tgt [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (lat=%0d, t=%0t): got %h expected %h", tag, lat_of(cur), $time, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] spc, input int slen, input bit rnd, input int nb,
                           input logic [31:0] b0, input logic [31:0] t0,
                           input logic [31:0] b1, input logic [31:0] t1);
        stall_pc   = spc;
        stall_len  = slen;
        rand_ready = rnd;
        nbr        = nb;
        br_pc[0]   = b0;
        br_tgt[0]  = t0;
        br_pc[1]   = b1;
        br_tgt[1]  = t1;
    endtask

    // Program-order model: a taken branch is followed by its delay slot, then the target;
    // a branch sitting in a delay slot is not taken.
    task automatic load_prog(input int n);
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          ds;
        pc  = 32'h0;
        tgt = 32'h0;
        ds  = 1'b0;
        sb.delete();
        for (int k = 0; k < n; k++) begin
            sb.push_back(pc);
            if (ds) begin
                ds = 1'b0;
                pc = tgt;
            end else begin
                for (int b = 0; b < nbr; b++) begin
                    if (pc == br_pc[b]) begin
                        ds  = 1'b1;
                        tgt = br_tgt[b];
                    end
                end
                pc = pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        id_ready[cur]    = 1'b0;
        branch_flag[cur] = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("rst_rom_ce", 32'(rom_ce[cur]), 32'h0);
        check_eq("rst_rom_addr", rom_addr[cur], 32'h0);
        check_eq("rst_id_valid", 32'(id_valid[cur]), 32'h0);
        check_eq("rst_id_pc", id_pc[cur], 32'h0);
        check_eq("rst_id_inst", id_inst[cur], 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_scn(input int budget);
        int          cyc;
        int          stalled;
        bit          rdy;
        logic [31:0] exp_pc;
        cyc     = 0;
        stalled = 0;
        while (sb.size() != 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            rdy = rand_ready ? ($urandom_range(1, 0) == 1) : 1'b1;
            if (id_valid[cur] && id_pc[cur] == stall_pc && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            id_ready[cur]      = rdy;
            branch_flag[cur]   = 1'b0;
            branch_target[cur] = '0;
            if (id_valid[cur] && rdy) begin
                exp_pc = sb.pop_front();
                check_eq("out_pc", id_pc[cur], exp_pc);
                check_eq("out_inst", id_inst[cur], inst_of(exp_pc));
                for (int b = 0; b < nbr; b++) begin
                    if (id_pc[cur] == br_pc[b]) begin
                        branch_flag[cur]   = 1'b1;
                        branch_target[cur] = br_tgt[b];
                    end
                end
            end
        end
        @(negedge clk);
        id_ready[cur]    = 1'b0;
        branch_flag[cur] = 1'b0;
        check_eq("drain_left", 32'(sb.size()), 32'h0);
    endtask

    task automatic scn_stall();
        int n_iss;
        int first_ce;
        int first_v;
        n_iss    = 0;
        first_ce = -1;
        first_v  = -1;
        set_cfg('1, 0, 1'b0, 0, '0, '0, '0, '0);
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rom_ce[cur]) begin
                check_eq("issue_addr", rom_addr[cur], 32'(n_iss * 4));
                n_iss++;
                if (first_ce < 0) first_ce = c;
            end
            if (id_valid[cur] && first_v < 0) first_v = c;
        end
        check_eq("stall_issues", 32'(n_iss), 32'd4);
        check_eq("stall_ce_off", 32'(rom_ce[cur]), 32'h0);
        check_eq("first_latency", 32'(first_v - first_ce), 32'(lat_of(cur) + 1));
        load_prog(8);
        run_scn(100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int g = 0; g < NI; g++) begin
            id_ready[g]      = 1'b0;
            branch_flag[g]   = 1'b0;
            branch_target[g] = '0;
        end
        set_cfg('1, 0, 1'b0, 0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);

        for (int d = 0; d < NI; d++) begin
            cur = d;

            scn_stall();

            // Queue full behind the branch; delay-slot branch must be ignored.
            set_cfg(32'h10, 12, 1'b0, 2, 32'h10, 32'h100, 32'h14, 32'h200);
            do_reset();
            load_prog(10);
            run_scn(150);

            // Free-running consumer: branch meets a short queue / in-flight fetches.
            set_cfg('1, 0, 1'b0, 1, 32'h10, 32'h100, '0, '0);
            do_reset();
            load_prog(10);
            run_scn(150);

            // Partial stall just before the branch.
            set_cfg(32'h8, 3, 1'b0, 2, 32'hC, 32'h80, 32'h10, 32'h300);
            do_reset();
            load_prog(10);
            run_scn(150);

            // Random back-pressure with two redirects.
            set_cfg('1, 0, 1'b1, 2, 32'h10, 32'h100, 32'h108, 32'h40);
            do_reset();
            load_prog(20);
            run_scn(400);

            // Reset asserted while fetches are in flight.
            set_cfg('1, 0, 1'b0, 0, '0, '0, '0, '0);
            do_reset();
            repeat (6) begin
                @(negedge clk);
                id_ready[cur] = 1'b1;
            end
            do_reset();
            load_prog(6);
            run_scn(100);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
